// File: rtl/trap_unit_if.sv
// trap_unit_if
//   Bundle between the core/controller/CSR side and the machine-mode trap
//   sequencer (trap_unit).
//   master : core side. It drives the interrupt levels, exception reports,
//            PCs, boundary/mret strobes and the live mstatus/mie.
//   slave  : trap_unit. It drives trap_req, the trap strobe, the registered
//            CSR capture values and in_handler.
interface trap_unit_if;
  logic        meip;
  logic        msip;
  logic        mtip;
  logic        exc_valid;
  logic        exc_fetch_mis;
  logic        exc_illegal;
  logic        exc_ebreak;
  logic        exc_ecall;
  logic [31:0] exc_tval;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        instr_done;
  logic        mret_in;
  logic [31:0] mstatus_cur;
  logic [31:0] mie_cur;
  logic        trap_req;
  logic        trap;
  logic [31:0] mepc;
  logic [31:0] mstatus_in;
  logic [31:0] mip_in;
  logic [31:0] mcause_in;
  logic [31:0] mtval;
  logic        in_handler;

  modport master (
    output meip, msip, mtip,
    output exc_valid, exc_fetch_mis, exc_illegal, exc_ebreak, exc_ecall,
    output exc_tval, pc, pc_next, instr_done, mret_in,
    output mstatus_cur, mie_cur,
    input  trap_req, trap, mepc, mstatus_in, mip_in, mcause_in, mtval,
    input  in_handler
  );

  modport slave (
    input  meip, msip, mtip,
    input  exc_valid, exc_fetch_mis, exc_illegal, exc_ebreak, exc_ecall,
    input  exc_tval, pc, pc_next, instr_done, mret_in,
    input  mstatus_cur, mie_cur,
    output trap_req, trap, mepc, mstatus_in, mip_in, mcause_in, mtval,
    output in_handler
  );
endinterface

// File: rtl/trap_unit.sv
// trap_unit
//   Machine-mode trap sequencer sitting upstream of the CSR file. It
//   prioritises synchronous exceptions over interrupts and waits for an
//   instruction boundary before taking an interrupt. It then emits a
//   one-cycle trap strobe with the registered values for
//   mepc/mstatus/mip/mcause/mtval, and tracks the handler until mret.
//
// Ports
//   clk, rst : clock and asynchronous active-high reset.
//   bus      : trap_unit_if.slave. Its inputs are the interrupt levels,
//              exception kind/tval, pc/pc_next, instr_done, mret_in and
//              mstatus_cur/mie_cur. Its outputs are trap_req, trap, mepc,
//              mstatus_in, mip_in, mcause_in, mtval and in_handler.
//
// Build option
//   TRAP_IRQ_SYNC_EN : when defined, meip/msip/mtip each pass through a
//                      2-flop synchronizer. This adds 2 cycles of interrupt
//                      latency. When undefined, the inputs must already be
//                      synchronous to clk.
//
// state  | meaning
// IDLE   | no trap in progress, watching for exceptions/interrupts
// PEND   | interrupt takeable, trap_req high, waiting for a boundary
// TRAP   | one-cycle trap strobe to the CSR file
// ACTIVE | handler running until mret; interrupts ignored
module trap_unit (
  input  logic         clk,
  input  logic         rst,
  trap_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_TRAP,
    S_ACTIVE
  } state_t;

  state_t      state;
  logic [2:0]  pend;        // {mei, mti, msi}
  logic [2:0]  irq_en;
  logic        irq_take;
  logic [3:0]  irq_code;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval_sel;
  logic [31:0] cap_epc;
  logic [31:0] cap_cause;
  logic [31:0] cap_tval;
  logic [31:0] cap_status;
  logic [31:0] cap_mip;

`ifdef TRAP_IRQ_SYNC_EN
  logic [2:0] irq_meta;
  logic [2:0] irq_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_meta <= 3'b000;
      irq_sync <= 3'b000;
    end else begin
      irq_meta <= {bus.meip, bus.mtip, bus.msip};
      irq_sync <= irq_meta;
    end
  end

  assign pend = irq_sync;
`else
  assign pend = {bus.meip, bus.mtip, bus.msip};
`endif

  // A line is takeable only when it is pending, its mie bit is set and
  // global MIE is set.
  assign irq_en   = pend & {bus.mie_cur[11], bus.mie_cur[7], bus.mie_cur[3]}
                  & {3{bus.mstatus_cur[3]}};
  assign irq_take = |irq_en;

  // MEI > MSI > MTI
  always_comb begin
    irq_code = 4'd7;
    if (irq_en[2])      irq_code = 4'd11;
    else if (irq_en[0]) irq_code = 4'd3;
  end

  // fetch-misaligned > illegal > ebreak > ecall
  always_comb begin
    exc_code     = 4'd11;
    exc_tval_sel = 32'd0;
    if (bus.exc_fetch_mis) begin
      exc_code     = 4'd0;
      exc_tval_sel = bus.exc_tval;
    end else if (bus.exc_illegal) begin
      exc_code     = 4'd2;
      exc_tval_sel = bus.exc_tval;
    end else if (bus.exc_ebreak) begin
      exc_code     = 4'd3;
    end
  end

  // Every capture path either has an exception (which always wins) or is an
  // interrupt taken at a boundary, so a single mux on exc_valid covers all.
  always_comb begin
    cap_status        = bus.mstatus_cur;
    cap_status[7]     = bus.mstatus_cur[3];
    cap_status[3]     = 1'b0;
    cap_status[12:11] = 2'b11;
    cap_mip           = {20'd0, pend[2], 3'd0, pend[1], 3'd0, pend[0], 3'd0};
    if (bus.exc_valid) begin
      cap_epc   = bus.pc;
      cap_cause = {28'd0, exc_code};
      cap_tval  = exc_tval_sel;
    end else begin
      cap_epc   = bus.pc_next;
      cap_cause = {1'b1, 27'd0, irq_code};
      cap_tval  = 32'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.mie_cur[31:12], bus.mie_cur[10:8],
                         bus.mie_cur[6:4], bus.mie_cur[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.trap       <= 1'b0;
      bus.trap_req   <= 1'b0;
      bus.in_handler <= 1'b0;
      bus.mepc       <= 32'd0;
      bus.mstatus_in <= 32'd0;
      bus.mip_in     <= 32'd0;
      bus.mcause_in  <= 32'd0;
      bus.mtval      <= 32'd0;
    end else begin
      bus.trap <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.exc_valid) begin
            state      <= S_TRAP;
            bus.trap   <= 1'b1;
            bus.mepc       <= cap_epc;
            bus.mstatus_in <= cap_status;
            bus.mip_in     <= cap_mip;
            bus.mcause_in  <= cap_cause;
            bus.mtval      <= cap_tval;
          end else if (irq_take) begin
            state        <= S_PEND;
            bus.trap_req <= 1'b1;
          end
        end
        S_PEND: begin
          if (bus.exc_valid || (bus.instr_done && irq_take)) begin
            state        <= S_TRAP;
            bus.trap     <= 1'b1;
            bus.trap_req <= 1'b0;
            bus.mepc       <= cap_epc;
            bus.mstatus_in <= cap_status;
            bus.mip_in     <= cap_mip;
            bus.mcause_in  <= cap_cause;
            bus.mtval      <= cap_tval;
          end else if (!irq_take) begin
            state        <= S_IDLE;
            bus.trap_req <= 1'b0;
          end
        end
        S_TRAP: begin
          state          <= S_ACTIVE;
          bus.in_handler <= 1'b1;
        end
        S_ACTIVE: begin
          if (bus.mret_in) begin
            state          <= S_IDLE;
            bus.in_handler <= 1'b0;
          end else if (bus.exc_valid) begin
            // nested exception: mepc and friends are overwritten
            state      <= S_TRAP;
            bus.trap   <= 1'b1;
            bus.mepc       <= cap_epc;
            bus.mstatus_in <= cap_status;
            bus.mip_in     <= cap_mip;
            bus.mcause_in  <= cap_cause;
            bus.mtval      <= cap_tval;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
module tb_trap_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trap_unit_if bus ();

  trap_unit u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef TRAP_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] status;
    logic [31:0] mip;
    logic [31:0] tval;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] status, input logic [31:0] mip,
                             input logic [31:0] tval);
    exp_t e;
    e.epc = epc; e.cause = cause; e.status = status; e.mip = mip; e.tval = tval;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_exc();
    bus.exc_valid     = 1'b0;
    bus.exc_fetch_mis = 1'b0;
    bus.exc_illegal   = 1'b0;
    bus.exc_ebreak    = 1'b0;
    bus.exc_ecall     = 1'b0;
    bus.exc_tval      = 32'd0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_trap"},       {31'd0, bus.trap},       32'd0);
    check({tag, "_trap_req"},   {31'd0, bus.trap_req},   32'd0);
    check({tag, "_in_handler"}, {31'd0, bus.in_handler}, 32'd0);
    check({tag, "_mepc"},       bus.mepc,       32'd0);
    check({tag, "_mstatus_in"}, bus.mstatus_in, 32'd0);
    check({tag, "_mip_in"},     bus.mip_in,     32'd0);
    check({tag, "_mcause_in"},  bus.mcause_in,  32'd0);
    check({tag, "_mtval"},      bus.mtval,      32'd0);
  endtask

  // Scoreboard: every trap strobe pops the next expected capture.
  always @(negedge clk) begin
    if (!rst && bus.trap === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_trap", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_mepc",    bus.mepc,       mon_e.epc);
        check("sb_mcause",  bus.mcause_in,  mon_e.cause);
        check("sb_mstatus", bus.mstatus_in, mon_e.status);
        check("sb_mip",     bus.mip_in,     mon_e.mip);
        check("sb_mtval",   bus.mtval,      mon_e.tval);
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.meip = 1'b0; bus.msip = 1'b0; bus.mtip = 1'b0;
    clear_exc();
    bus.pc = 32'd0; bus.pc_next = 32'd0;
    bus.instr_done = 1'b0; bus.mret_in = 1'b0;
    bus.mstatus_cur = 32'd0; bus.mie_cur = 32'd0;
    repeat (2) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // ecall from IDLE
    bus.exc_valid = 1'b1; bus.exc_ecall = 1'b1;
    bus.pc = 32'h100; bus.mstatus_cur = 32'h8;
    expect_trap(32'h100, 32'hB, 32'h1880, 32'h0, 32'h0);
    step();
    check("exc_latency", {31'd0, bus.trap}, 32'd1);
    clear_exc();
    step();
    check("trap_one_cycle", {31'd0, bus.trap}, 32'd0);
    check("in_handler_on", {31'd0, bus.in_handler}, 32'd1);

    // nested illegal-instruction exception in ACTIVE
    bus.exc_valid = 1'b1; bus.exc_illegal = 1'b1; bus.exc_tval = 32'hFFFF_FFFF;
    bus.pc = 32'h200; bus.mstatus_cur = 32'h1880;
    expect_trap(32'h200, 32'h2, 32'h1800, 32'h0, 32'hFFFF_FFFF);
    step();
    check("nest_latency", {31'd0, bus.trap}, 32'd1);
    clear_exc();
    step();
    bus.mret_in = 1'b1;
    step();
    bus.mret_in = 1'b0;
    check("mret_exit", {31'd0, bus.in_handler}, 32'd0);

    // fetch-misaligned beats ecall; tval passed through
    bus.exc_valid = 1'b1; bus.exc_fetch_mis = 1'b1; bus.exc_ecall = 1'b1;
    bus.exc_tval = 32'h1234; bus.pc = 32'h500; bus.mstatus_cur = 32'h8;
    expect_trap(32'h500, 32'h0, 32'h1880, 32'h0, 32'h1234);
    step();
    check("fetch_prio_trap", {31'd0, bus.trap}, 32'd1);
    clear_exc();
    step();
    bus.mret_in = 1'b1;
    step();
    bus.mret_in = 1'b0;

    // MEI + MTI at a boundary
    bus.mie_cur = 32'h888; bus.mstatus_cur = 32'h8;
    bus.meip = 1'b1; bus.mtip = 1'b1;
    repeat (LAT) step();
    check("irq_req", {31'd0, bus.trap_req}, 32'd1);
    bus.instr_done = 1'b1; bus.pc_next = 32'h204;
    expect_trap(32'h204, 32'h8000_000B, 32'h1880, 32'h880, 32'h0);
    step();
    check("irq_trap", {31'd0, bus.trap}, 32'd1);
    bus.instr_done = 1'b0; bus.meip = 1'b0; bus.mtip = 1'b0;
    step();
    bus.mret_in = 1'b1;
    step();
    bus.mret_in = 1'b0;
    repeat (LAT + 3) step();
    check("irq_quiet", {31'd0, bus.trap_req}, 32'd0);

    // MIE gating, then cancellation by dropping the line
    bus.mstatus_cur = 32'h0; bus.mtip = 1'b1;
    repeat (LAT + 1) step();
    check("mie_off_req", {31'd0, bus.trap_req}, 32'd0);
    bus.mstatus_cur = 32'h8;
    step();
    check("mie_on_req", {31'd0, bus.trap_req}, 32'd1);
    bus.mtip = 1'b0;
    repeat (LAT + 1) step();
    check("cancel_req", {31'd0, bus.trap_req}, 32'd0);
    check("cancel_trap", {31'd0, bus.trap}, 32'd0);

    // exception and boundary together in PEND: exception wins
    bus.mtip = 1'b1;
    repeat (LAT) step();
    check("pend_req", {31'd0, bus.trap_req}, 32'd1);
    bus.exc_valid = 1'b1; bus.exc_ebreak = 1'b1;
    bus.pc = 32'h300; bus.pc_next = 32'h304; bus.instr_done = 1'b1;
    expect_trap(32'h300, 32'h3, 32'h1880, 32'h80, 32'h0);
    step();
    check("exc_wins_trap", {31'd0, bus.trap}, 32'd1);
    check("exc_wins_req", {31'd0, bus.trap_req}, 32'd0);
    clear_exc(); bus.instr_done = 1'b0;
    step();
    bus.mret_in = 1'b1;
    step();
    bus.mret_in = 1'b0;
    step();
    check("req_after_mret", {31'd0, bus.trap_req}, 32'd1);
    bus.mtip = 1'b0;
    repeat (LAT + 2) step();

    // MSI latency measurement, then reset while ACTIVE
    bus.msip = 1'b1;
    n = 0;
    while (bus.trap_req !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("msi_latency", n, LAT);
    bus.instr_done = 1'b1; bus.pc_next = 32'h404;
    expect_trap(32'h404, 32'h8000_0003, 32'h1880, 32'h8, 32'h0);
    step();
    check("msi_trap", {31'd0, bus.trap}, 32'd1);
    bus.instr_done = 1'b0; bus.msip = 1'b0;
    step();
    check("pre_rst_handler", {31'd0, bus.in_handler}, 32'd1);
    #2 rst = 1'b1;
    #1 check_outputs_zero("async_rst");
    repeat (2) step();
    rst = 1'b0;
    repeat (LAT + 2) step();
    check("post_rst_req", {31'd0, bus.trap_req}, 32'd0);
    check("post_rst_handler", {31'd0, bus.in_handler}, 32'd0);

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
